// File: rtl/guess_ctrl.sv
// ---------------------------------------------------------------------------
// guess_ctrl
//
// Round control for the number-guessing game. Sits directly in front of the
// comparator/LED stage. It produces the secret from a free-running LFSR,
// debounces the two board buttons, latches each submitted guess, counts
// attempts and runs the round state machine (IDLE / PLAY / WIN / LOSE).
//
// Ports
//   i_clk          system clock, single domain
//   i_rst_n        asynchronous active-low reset (0 = reset)
//   i_sw_guess     raw guess switches, sampled when a guess press is accepted
//   i_btn_new      raw "new round" button, asynchronous, active-high
//   i_btn_guess    raw "submit guess" button, asynchronous, active-high
//   o_rand         secret for the current round
//   o_data_in      last submitted guess
//   o_count        guesses submitted this round
//   o_guess_valid  one-cycle pulse when o_data_in / o_count update
//   o_state        0 = IDLE, 1 = PLAY, 2 = WIN, 3 = LOSE
//   o_game_over    high in WIN or LOSE
//
// Handshake: there is no backpressure. o_guess_valid is a single-cycle
// strobe that is high in exactly the cycle o_data_in, o_count and o_state
// first show the result of an accepted guess; the consumer must sample it
// on that cycle. All outputs are registered.
// ---------------------------------------------------------------------------
module guess_ctrl #(
  parameter logic [7:0]  LFSR_SEED    = 8'hA5, // must be nonzero
  parameter int unsigned MAX_TRIES    = 7,     // 1..7
  parameter int unsigned DEBOUNCE_CYC = 16     // >= 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_sw_guess,
  input  logic       i_btn_new,
  input  logic       i_btn_guess,
  output logic [7:0] o_rand,
  output logic [7:0] o_data_in,
  output logic [2:0] o_count,
  output logic       o_guess_valid,
  output logic [1:0] o_state,
  output logic       o_game_over
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_WIN  = 2'd2,
    S_LOSE = 2'd3
  } state_t;

  localparam int unsigned CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  // The counter flips the debounced level on the edge where it would reach
  // DEBOUNCE_CYC, so it only ever needs to hold 0..DEBOUNCE_CYC-1.
  localparam logic [CW-1:0] LP_DB_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [2:0]    LP_MAX     = 3'(MAX_TRIES);

  // Button index 0 = new round, 1 = submit guess.
  localparam int unsigned B_NEW   = 0;
  localparam int unsigned B_GUESS = 1;

  // -------------------------------------------------------------------------
  // LFSR: Fibonacci x^8+x^6+x^5+x^4+1, runs every cycle regardless of state.
  // -------------------------------------------------------------------------
  logic [7:0] r_lfsr;
  logic       w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
    end
  end

  // -------------------------------------------------------------------------
  // Button conditioning: 2-flop synchronizer, debounce counter, and a
  // registered copy of the debounced level for rising-edge detection.
  // -------------------------------------------------------------------------
  logic [1:0]    w_btn_raw;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_deb;
  logic [1:0]    r_deb_q;
  logic [CW-1:0] r_db_cnt [2];
  logic          w_new_ev;
  logic          w_guess_ev;

  assign w_btn_raw = {i_btn_guess, i_btn_new};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_q <= '0;
      for (int i = 0; i < 2; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          // Any return to the accepted level restarts the stability window.
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == LP_DB_LAST) begin
          r_deb[i]    <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press events only; release edges are ignored.
  assign w_new_ev   = r_deb[B_NEW]   & ~r_deb_q[B_NEW];
  assign w_guess_ev = r_deb[B_GUESS] & ~r_deb_q[B_GUESS];

  // -------------------------------------------------------------------------
  // Round state machine with registered outputs.
  // -------------------------------------------------------------------------
  state_t     r_state;
  logic [7:0] r_rand;
  logic [7:0] r_data_in;
  logic [2:0] r_count;
  logic       r_guess_valid;
  logic       r_game_over;
  logic [2:0] w_count_inc;

  // Never wraps: PLAY is left once the count reaches MAX_TRIES (<= 7).
  assign w_count_inc = r_count + 3'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_rand        <= '0;
      r_data_in     <= '0;
      r_count       <= '0;
      r_guess_valid <= 1'b0;
      r_game_over   <= 1'b0;
    end else begin
      r_guess_valid <= 1'b0;
      if (w_new_ev) begin
        // A new round takes priority; a guess in the same cycle is dropped.
        r_rand      <= r_lfsr;
        r_data_in   <= '0;
        r_count     <= '0;
        r_state     <= S_PLAY;
        r_game_over <= 1'b0;
      end else if (w_guess_ev && (r_state == S_PLAY)) begin
        r_data_in     <= i_sw_guess;
        r_count       <= w_count_inc;
        r_guess_valid <= 1'b1;
        if (i_sw_guess == r_rand) begin
          r_state     <= S_WIN;
          r_game_over <= 1'b1;
        end else if (w_count_inc == LP_MAX) begin
          r_state     <= S_LOSE;
          r_game_over <= 1'b1;
        end
      end
    end
  end

  assign o_rand        = r_rand;
  assign o_data_in     = r_data_in;
  assign o_count       = r_count;
  assign o_guess_valid = r_guess_valid;
  assign o_state       = r_state;
  assign o_game_over   = r_game_over;

endmodule

// File: tb/tb_guess_ctrl.sv
// ---------------------------------------------------------------------------
// tb_guess_ctrl
//
// Directed bench for guess_ctrl with the default parameters
// (seed 8'hA5, 7 tries, 16-cycle debounce).
// ---------------------------------------------------------------------------
module tb_guess_ctrl;

  localparam logic [7:0]  SEED   = 8'hA5;
  localparam int unsigned TRIES  = 7;
  localparam int unsigned DB_CYC = 16;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic       clk;
  logic       rst_n;
  logic [7:0] sw_guess;
  logic       btn_new;
  logic       btn_guess;
  logic [7:0] o_rand;
  logic [7:0] o_data_in;
  logic [2:0] o_count;
  logic       o_guess_valid;
  logic [1:0] o_state;
  logic       o_game_over;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  guess_ctrl #(
    .LFSR_SEED    (SEED),
    .MAX_TRIES    (TRIES),
    .DEBOUNCE_CYC (DB_CYC)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_sw_guess    (sw_guess),
    .i_btn_new     (btn_new),
    .i_btn_guess   (btn_guess),
    .o_rand        (o_rand),
    .o_data_in     (o_data_in),
    .o_count       (o_count),
    .o_guess_valid (o_guess_valid),
    .o_state       (o_state),
    .o_game_over   (o_game_over)
  );

  // -------------------------------------------------------------------------
  // Reference LFSR (x^8+x^6+x^5+x^4+1) and guess_valid pulse counter
  // -------------------------------------------------------------------------
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  logic [7:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= lfsr_next(m_lfsr);
  end

  int gv_cnt;
  initial gv_cnt = 0;
  always @(negedge clk) begin
    if (o_guess_valid === 1'b1) gv_cnt++;
  end

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks (entered and left on a falling edge)
  // -------------------------------------------------------------------------
  // Raise the selected buttons and wait until the output update edge
  // (DB_CYC+3). Returns the state one edge early, the reference LFSR value
  // that the event edge registers, and guess_valid after the update edge.
  task automatic press(input logic do_new, input logic do_guess,
                       output logic [1:0] pre_state, output logic [7:0] ev_lfsr,
                       output logic gv);
    btn_new   = do_new;
    btn_guess = do_guess;
    repeat (DB_CYC + 2) @(posedge clk);
    @(negedge clk);
    pre_state = o_state;
    ev_lfsr   = m_lfsr;
    @(posedge clk);
    @(negedge clk);
    gv = o_guess_valid;
  endtask

  task automatic release_btns();
    btn_new   = 1'b0;
    btn_guess = 1'b0;
    repeat (DB_CYC + 6) @(negedge clk);
  endtask

  // Submit one wrong guess (value g) and check the resulting count.
  task automatic wrong_guess(input logic [7:0] g, input int exp_cnt, input string tag);
    logic [1:0] ps;
    logic [7:0] ev;
    logic       gv;
    sw_guess = g;
    press(1'b0, 1'b1, ps, ev, gv);
    check({tag, "_gv"}, 32'(gv), 32'd1);
    check({tag, "_count"}, 32'(o_count), 32'(exp_cnt));
    release_btns();
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  logic [1:0] ps;
  logic [7:0] ev;
  logic       gv;
  logic [7:0] r_secret;
  int         gv_before;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    sw_guess  = 8'h00;
    btn_new   = 1'b0;
    btn_guess = 1'b0;

    // Reset / idle
    repeat (3) @(negedge clk);
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_rand", 32'(o_rand), 32'd0);
    check("rst_data", 32'(o_data_in), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_gv", 32'(o_guess_valid), 32'd0);
    check("rst_go", 32'(o_game_over), 32'd0);
    check("rst_lfsr", 32'(dut.r_lfsr), 32'(SEED));
    rst_n = 1'b1;
    @(negedge clk);

    btn_guess = 1'b1;
    repeat (40) @(negedge clk);
    release_btns();
    check("idle_gv_cnt", 32'(gv_cnt), 32'd0);
    check("idle_count", 32'(o_count), 32'd0);
    check("idle_state", 32'(o_state), 32'd0);

    // Glitch shorter than the debounce window
    btn_new = 1'b1;
    repeat (10) @(negedge clk);
    btn_new = 1'b0;
    repeat (30) @(negedge clk);
    check("glitch_state", 32'(o_state), 32'd0);
    check("glitch_rand", 32'(o_rand), 32'd0);

    // New round: state changes exactly at edge DB_CYC+3
    press(1'b1, 1'b0, ps, ev, gv);
    check("new_pre_state", 32'(ps), 32'd0);
    check("new_state", 32'(o_state), 32'd1);
    check("new_rand", 32'(o_rand), 32'(ev));
    check("new_rand_nz", 32'(o_rand != 8'h00), 32'd1);
    check("new_count", 32'(o_count), 32'd0);
    check("new_gv", 32'(gv), 32'd0);
    release_btns();
    check("held_state", 32'(o_state), 32'd1);
    r_secret = ev;

    // Win path
    sw_guess = r_secret ^ 8'h01;
    press(1'b0, 1'b1, ps, ev, gv);
    check("win1_gv", 32'(gv), 32'd1);
    check("win1_count", 32'(o_count), 32'd1);
    check("win1_data", 32'(o_data_in), 32'(r_secret ^ 8'h01));
    check("win1_state", 32'(o_state), 32'd1);
    release_btns();
    check("win1_gv_cnt", 32'(gv_cnt), 32'd1);

    sw_guess = r_secret;
    press(1'b0, 1'b1, ps, ev, gv);
    check("win2_gv", 32'(gv), 32'd1);
    check("win2_count", 32'(o_count), 32'd2);
    check("win2_state", 32'(o_state), 32'd2);
    check("win2_go", 32'(o_game_over), 32'd1);
    release_btns();

    press(1'b0, 1'b1, ps, ev, gv);
    check("win3_gv", 32'(gv), 32'd0);
    check("win3_count", 32'(o_count), 32'd2);
    check("win3_state", 32'(o_state), 32'd2);
    release_btns();
    check("win3_gv_cnt", 32'(gv_cnt), 32'd2);

    // Lose path
    press(1'b1, 1'b0, ps, ev, gv);
    check("lose_new_state", 32'(o_state), 32'd1);
    check("lose_new_rand", 32'(o_rand), 32'(ev));
    check("lose_new_go", 32'(o_game_over), 32'd0);
    release_btns();
    r_secret = ev;
    for (int i = 1; i <= 7; i++) begin
      wrong_guess(r_secret ^ 8'(i), i, "lose");
      check("lose_data", 32'(o_data_in), 32'(r_secret ^ 8'(i)));
      check("lose_state", 32'(o_state), (i == 7) ? 32'd3 : 32'd1);
      check("lose_go", 32'(o_game_over), (i == 7) ? 32'd1 : 32'd0);
    end
    gv_before = gv_cnt;
    press(1'b0, 1'b1, ps, ev, gv);
    check("lose8_gv", 32'(gv), 32'd0);
    check("lose8_count", 32'(o_count), 32'd7);
    check("lose8_state", 32'(o_state), 32'd3);
    release_btns();
    check("lose8_gv_cnt", 32'(gv_cnt), 32'(gv_before));

    // Simultaneous new + guess in PLAY with count 3
    press(1'b1, 1'b0, ps, ev, gv);
    release_btns();
    r_secret = ev;
    for (int i = 1; i <= 3; i++) wrong_guess(r_secret ^ 8'h80 ^ 8'(i), i, "sim");
    gv_before = gv_cnt;
    sw_guess  = 8'h5A;
    press(1'b1, 1'b1, ps, ev, gv);
    check("sim_gv", 32'(gv), 32'd0);
    check("sim_count", 32'(o_count), 32'd0);
    check("sim_data", 32'(o_data_in), 32'd0);
    check("sim_state", 32'(o_state), 32'd1);
    check("sim_rand", 32'(o_rand), 32'(ev));
    release_btns();
    check("sim_gv_cnt", 32'(gv_cnt), 32'(gv_before));

    // Reset mid-game with count 4
    r_secret = ev;
    for (int i = 1; i <= 4; i++) wrong_guess(r_secret ^ 8'h40 ^ 8'(i), i, "mid");
    btn_new = 1'b1;       // press in progress when reset hits
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_state", 32'(o_state), 32'd0);
    check("mid_count", 32'(o_count), 32'd0);
    check("mid_data", 32'(o_data_in), 32'd0);
    check("mid_rand", 32'(o_rand), 32'd0);
    check("mid_go", 32'(o_game_over), 32'd0);
    check("mid_lfsr", 32'(dut.r_lfsr), 32'(SEED));
    @(negedge clk);
    btn_new = 1'b0;
    rst_n   = 1'b1;
    repeat (DB_CYC + 6) @(negedge clk);
    check("post_rst_state", 32'(o_state), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/guess_ctrl.md
# guess_ctrl

Game-control stage placed directly upstream of the guess comparator/LED stage. Generates the 8-bit secret from a free-running LFSR, debounces the board buttons, latches each submitted switch guess, and counts attempts. Drives the comparator's `rand`, `data_in` and `count` inputs and runs the round state machine (idle / play / win / lose).

## Interface
Parameters:
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be nonzero.
- `MAX_TRIES`, 7: attempts per round, legal range 1..7.
- `DEBOUNCE_CYC`, 16: cycles a synchronized button level must be stable before it is accepted, ≥2.

Ports:
- `clk`  in  1  system clock, single domain.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `sw_guess`  in  8  raw guess switches, sampled on accepted guess press.
- `btn_new`  in  1  raw "new round" button, asynchronous, active-high.
- `btn_guess`  in  1  raw "submit guess" button, asynchronous, active-high.
- `rand`  out  8  secret for the current round.
- `data_in`  out  8  last submitted guess.
- `count`  out  3  guesses submitted this round.
- `guess_valid`  out  1  one-cycle pulse when `data_in` and `count` update.
- `state`  out  2  0 = IDLE, 1 = PLAY, 2 = WIN, 3 = LOSE.
- `game_over`  out  1  high in WIN or LOSE.

## Operation
- LFSR: 8-bit Fibonacci, taps 8,6,5,4 (x^8+x^6+x^5+x^4+1), advances every cycle in every state. Period 255, never zero.
- Button path, per button: 2-flop synchronizer, then debounce counter. The counter resets whenever the synchronized level equals the debounced level. Otherwise it increments. When it reaches `DEBOUNCE_CYC`, the debounced level takes the new value.
- Rising-edge detect on the debounced level gives a one-cycle `new_ev` / `guess_ev`. Release edges are ignored.
- FSM:
  - Any state, `new_ev`: `rand` <= current LFSR value, `count` <= 0, `data_in` <= 0, go to PLAY.
  - PLAY, `guess_ev`: `data_in` <= `sw_guess`, `count` <= `count`+1, pulse `guess_valid`.
    - If `sw_guess` == `rand`, go to WIN.
    - Else if `count`+1 == `MAX_TRIES`, go to LOSE.
    - Else stay in PLAY.
  - IDLE / WIN / LOSE, `guess_ev`: ignored. No pulse, outputs hold.
- `new_ev` and `guess_ev` in the same cycle: `new_ev` wins and the guess is dropped.
- `count` never exceeds `MAX_TRIES`, so the 3-bit counter does not wrap.
- Comparison is unsigned 8-bit equality.
- `game_over` = (`state` == WIN) | (`state` == LOSE), registered together with `state`.

## Timing
- Reset values (asserted asynchronously when `rst`=0):
  - `rand`=0, `data_in`=0, `count`=0, `guess_valid`=0, `state`=IDLE, `game_over`=0.
  - LFSR=`LFSR_SEED`; synchronizers, debounced levels and debounce counters = 0.
- Reset release: the first active edge occurs on the first `clk` rise with `rst`=1. The LFSR holds `LFSR_SEED` until then.
- All outputs are registered with no combinational path from input to output.
- Latency: a clean raw rising edge stable from cycle 0 produces its event, and the resulting output update, at cycle `DEBOUNCE_CYC`+3: 2 synchronizer cycles, `DEBOUNCE_CYC` debounce cycles, 1 register cycle.
- A glitch shorter than `DEBOUNCE_CYC` synchronized cycles produces no event.
- `rand` is the LFSR value registered in the same edge that sees `new_ev`.
- `guess_valid` is high for exactly one cycle per accepted guess, aligned with the new `data_in`, `count` and `state`.
- A held button produces exactly one event. A new event requires release (debounced 0), then press again.
- Reset mid-round: immediate return to IDLE with all outputs cleared. A press in progress is discarded.

## Test plan
- Reset/idle: hold `rst`=0, then release. Require all outputs 0 and `state`=0. Pulse `btn_guess` for 40 cycles → no `guess_valid`, `count` stays 0.
- Debounce, `DEBOUNCE_CYC`=16:
  - `btn_new` high for 10 cycles → no change.
  - `btn_new` held high → `state`=1 at exactly cycle 19. `rand` is nonzero and equals the LFSR value the model predicts from `LFSR_SEED`.
- Win: in PLAY with `rand`=R, set `sw_guess`=R^1 and press → `count`=1, `data_in`=R^1, `state`=1. Set `sw_guess`=R and press → `count`=2, `state`=2, `game_over`=1. A further guess press is ignored.
- Lose: `MAX_TRIES`=7, submit 7 wrong guesses → `count` steps 1..7, `state`=3 on the 7th, `game_over`=1. An 8th press gives no pulse and `count` stays 7.
- Simultaneous: press both buttons with identical timing while in PLAY with `count`=3 → `count`=0, `data_in`=0, new `rand`, no `guess_valid`.
- Reset mid-game: in PLAY with `count`=4, drive `rst`=0 asynchronously between clock edges → outputs clear before the next edge, `state`=0, LFSR=8'hA5.
